// File: rtl/fwd_pkg.sv
// ---------------------------------------------------------------------------
// fwd_pkg
//   Shared definitions for the EX-stage operand forwarding controller:
//   forward-select codes, the per-stage shadow metadata record, the bubble
//   constant and a helper that decides whether a stage is a usable producer.
//   Configuration macro: FWD_WB2_EN (adds the WB+1 forwarding source, code 11).
// ---------------------------------------------------------------------------
package fwd_pkg;

    // Register index width carried in the stage shadows.
    localparam int FWD_RD_W = 5;

    // Operand mux select codes {sel1, sel0}.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,   // register file
        FWD_MEM = 2'b01,   // EX/MEM ALU result
        FWD_WB  = 2'b10,   // MEM/WB result
        FWD_WB2 = 2'b11    // WB+1 result (only with FWD_WB2_EN)
    } fwd_sel_e;

    // Shadow metadata tracked for each pipeline stage.
    typedef struct packed {
        logic [FWD_RD_W-1:0] rd;
        logic                we;
        logic                mem_read;
    } stage_meta_t;

    localparam stage_meta_t STAGE_BUBBLE = '{rd: '0, we: 1'b0, mem_read: 1'b0};

    // A stage can supply a value only if it writes a register, and, when x0 is
    // hardwired, only if that register is not x0.
    function automatic logic stage_writes(stage_meta_t s, logic x0_hardwired);
        return s.we && (!x0_hardwired || (s.rd != '0));
    endfunction

endpackage

// File: rtl/fwd_match.sv
// ---------------------------------------------------------------------------
// fwd_match
//   Combinational priority compare of one ID source register against the
//   stage shadows that will sit ahead of it once it reaches EX. The youngest
//   producer wins.
//   Configuration macro: FWD_WB2_EN adds the i_wb port and code FWD_WB2.
// Ports
//   i_rs    in   FWD_RD_W      source register index
//   i_used  in   1             instruction actually reads i_rs
//   i_ex    in   stage_meta_t  current EX shadow (MEM next cycle)   -> 01
//   i_mem   in   stage_meta_t  current MEM shadow (WB next cycle)   -> 10
//   i_wb    in   stage_meta_t  current WB shadow (FWD_WB2_EN only)  -> 11
//   o_sel   out  fwd_sel_e     forward select code
// ---------------------------------------------------------------------------
module fwd_match
    import fwd_pkg::*;
#(
    parameter bit X0_HARDWIRED = 1'b1
) (
    input  logic [FWD_RD_W-1:0] i_rs,
    input  logic                i_used,
    input  stage_meta_t         i_ex,
    input  stage_meta_t         i_mem,
`ifdef FWD_WB2_EN
    input  stage_meta_t         i_wb,
`endif
    output fwd_sel_e            o_sel
);

    logic w_hit_ex;
    logic w_hit_mem;

    assign w_hit_ex  = stage_writes(i_ex,  X0_HARDWIRED) && (i_ex.rd  == i_rs);
    assign w_hit_mem = stage_writes(i_mem, X0_HARDWIRED) && (i_mem.rd == i_rs);

`ifdef FWD_WB2_EN
    logic w_hit_wb;
    assign w_hit_wb = stage_writes(i_wb, X0_HARDWIRED) && (i_wb.rd == i_rs);
`endif

    always_comb begin
        // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
        o_sel = FWD_RF;
        if (i_used) begin
            if (w_hit_ex) begin
                o_sel = FWD_MEM;
            end else if (w_hit_mem) begin
                o_sel = FWD_WB;
            end
`ifdef FWD_WB2_EN
            else if (w_hit_wb) begin
                o_sel = FWD_WB2;
            end
`endif
        end
    end

    // Load flags are irrelevant to forwarding; only the stall logic needs them.
    logic w_unused;
`ifdef FWD_WB2_EN
    assign w_unused = ^{i_ex.mem_read, i_mem.mem_read, i_wb.mem_read};
`else
    assign w_unused = ^{i_ex.mem_read, i_mem.mem_read};
`endif

endmodule

// File: rtl/operand_fwd_ctrl.sv
// ---------------------------------------------------------------------------
// operand_fwd_ctrl
//   Drives the select lines of the two EX-stage 4:1 operand muxes (A, B).
//   Shadows {rd, we, mem_read} for EX, MEM and WB, detects RAW hazards for the
//   instruction in ID and registers its forward selects so they are valid
//   while that instruction is in EX. A load followed by a dependent consumer
//   raises a one-cycle stall and a bubble is inserted into EX.
//   Configuration macro: FWD_WB2_EN adds a WB2 shadow stage and the WB+1
//   forwarding source (code 11) for register files without write-before-read.
// Parameters
//   REG_ADDR_W    register index width (must equal fwd_pkg::FWD_RD_W)
//   X0_HARDWIRED  1: rd==0 is never forwarded and never stalls
// Ports
//   clk          in   1           rising-edge clock
//   rst_n        in   1           async active-low reset
//   id_valid     in   1           ID holds a real instruction
//   id_rs1       in   REG_ADDR_W  ID source 1
//   id_rs2       in   REG_ADDR_W  ID source 2
//   id_rs1_used  in   1           instruction reads rs1
//   id_rs2_used  in   1           instruction reads rs2
//   id_rd        in   REG_ADDR_W  ID destination
//   id_we        in   1           ID writes rd
//   id_mem_read  in   1           ID is a load
//   flush        in   1           branch taken: kill ID instruction
//   stall        out  1           hold PC and IF/ID (combinational)
//   ex_sel_a1/0  out  1           operand A select bits (registered)
//   ex_sel_b1/0  out  1           operand B select bits (registered)
// ---------------------------------------------------------------------------
module operand_fwd_ctrl
    import fwd_pkg::*;
#(
    parameter int REG_ADDR_W   = FWD_RD_W,
    parameter bit X0_HARDWIRED = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_we,
    input  logic                  id_mem_read,
    input  logic                  flush,
    output logic                  stall,
    output logic                  ex_sel_a1,
    output logic                  ex_sel_a0,
    output logic                  ex_sel_b1,
    output logic                  ex_sel_b0
);

    // The shadow record has a fixed index width; refuse to elaborate otherwise.
    if (REG_ADDR_W != FWD_RD_W) begin : g_width_check
        $error("operand_fwd_ctrl: REG_ADDR_W must equal fwd_pkg::FWD_RD_W");
    end

    stage_meta_t r_ex;
    stage_meta_t r_mem;
    stage_meta_t r_wb;
`ifdef FWD_WB2_EN
    stage_meta_t r_wb2;
`endif
    fwd_sel_e    r_sel_a;
    fwd_sel_e    r_sel_b;

    stage_meta_t w_id_meta;
    logic        w_ex_is_load;
    logic        w_load_use;
    logic        w_ex_bubble_next;
    fwd_sel_e    w_sel_a;
    fwd_sel_e    w_sel_b;

    assign w_id_meta = '{rd: id_rd, we: id_we, mem_read: id_mem_read};

    // Load-use: the load in EX has no value to forward until it reaches MEM/WB.
    assign w_ex_is_load = r_ex.mem_read && stage_writes(r_ex, X0_HARDWIRED);
    assign w_load_use   = w_ex_is_load &&
                          ((id_rs1_used && (id_rs1 == r_ex.rd)) ||
                           (id_rs2_used && (id_rs2 == r_ex.rd)));

    // A flush kills the ID instruction, so it also suppresses the stall.
    assign stall            = id_valid && w_load_use && !flush;
    assign w_ex_bubble_next = stall || flush || !id_valid;

    // Sources are compared against the stages as they stand now: current EX
    // becomes MEM (code 01) and current MEM becomes WB (code 10) next cycle.
    fwd_match #(.X0_HARDWIRED(X0_HARDWIRED)) u_match_a (
        .i_rs   (id_rs1),
        .i_used (id_rs1_used),
        .i_ex   (r_ex),
        .i_mem  (r_mem),
`ifdef FWD_WB2_EN
        .i_wb   (r_wb),
`endif
        .o_sel  (w_sel_a)
    );

    fwd_match #(.X0_HARDWIRED(X0_HARDWIRED)) u_match_b (
        .i_rs   (id_rs2),
        .i_used (id_rs2_used),
        .i_ex   (r_ex),
        .i_mem  (r_mem),
`ifdef FWD_WB2_EN
        .i_wb   (r_wb),
`endif
        .o_sel  (w_sel_b)
    );

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex    <= STAGE_BUBBLE;
            r_mem   <= STAGE_BUBBLE;
            r_wb    <= STAGE_BUBBLE;
`ifdef FWD_WB2_EN
            r_wb2   <= STAGE_BUBBLE;
`endif
            r_sel_a <= FWD_RF;
            r_sel_b <= FWD_RF;
        end else begin
            r_mem <= r_ex;
            r_wb  <= r_mem;
`ifdef FWD_WB2_EN
            r_wb2 <= r_wb;
`endif
            if (w_ex_bubble_next) begin
                r_ex    <= STAGE_BUBBLE;
                r_sel_a <= FWD_RF;
                r_sel_b <= FWD_RF;
            end else begin
                r_ex    <= w_id_meta;
                r_sel_a <= w_sel_a;
                r_sel_b <= w_sel_b;
            end
        end
    end

    assign ex_sel_a1 = r_sel_a[1];
    assign ex_sel_a0 = r_sel_a[0];
    assign ex_sel_b1 = r_sel_b[1];
    assign ex_sel_b0 = r_sel_b[0];

    // The last shadow stage is tracked for pipeline visibility but never matched.
    logic w_unused;
`ifdef FWD_WB2_EN
    assign w_unused = ^{r_wb2, r_mem.mem_read};
`else
    assign w_unused = ^{r_wb, r_mem.mem_read};
`endif

endmodule
